crc_serial_tx: RTL and testbench

- Bit-serial CRC framer downstream of the combinational CRC stage in the 6-bit-data / 4-bit-generator CRC path.
- Accepts one DATA_W-bit payload plus generator polynomial per frame via valid/ready handshake.
- Transmits the codeword {payload, crc} MSB first, one bit per accepted beat.
- Computes the CRC on the fly with a CRC_W-bit LFSR, so the serial stream needs no second pass.

---
 rtl/crc_pkg.sv | 21 ++
 rtl/crc_lfsr_step.sv | 16 +
 rtl/crc_serial_tx.sv | 128 ++++++++++++
 tb/tb_crc_serial_tx.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared types and defaults for the bit-serial CRC framer path.
package crc_pkg;

  localparam int DATA_W_DEFAULT = 6;
  localparam int CRC_W_DEFAULT  = 3;
  localparam logic [3:0] CRC_POLY_DEFAULT = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_e;

  // Counter must hold the larger of DATA_W-1 and CRC_W-1.
  function automatic int cnt_width(input int data_w, input int crc_w);
    int m;
    m = (data_w > crc_w) ? data_w : crc_w;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit CRC LFSR update in GF(2): shifts r left and folds in poly when feedback is set.
module crc_lfsr_step #(
  parameter int CRC_W = 3
) (
  input  logic [CRC_W-1:0] r,
  input  logic             b,
  input  logic [CRC_W-1:0] poly,
  output logic [CRC_W-1:0] r_next
);

  logic fb;

  assign fb     = r[CRC_W-1] ^ b;
  assign r_next = {r[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);

endmodule

// File: rtl/crc_serial_tx.sv
// Bit-serial framer: sends {payload, crc} MSB first, computing the CRC on the fly.
module crc_serial_tx
  import crc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CRC_W  = CRC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CRC_W:0]    genpoly,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_bit,
  output logic              ser_last,
  output logic              frame_done,
  output logic [CRC_W-1:0]  crc_out
);

  localparam int CNT_W = cnt_width(DATA_W, CRC_W);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CRC_W-1:0]   poly_q, poly_d;
  logic [CRC_W-1:0]   r_q, r_d;
  logic [CRC_W-1:0]   crc_hold_q, crc_hold_d;
  logic [CRC_W-1:0]   crc_out_q, crc_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [CRC_W-1:0]   r_step;

  crc_lfsr_step #(.CRC_W(CRC_W)) u_lfsr_step (
    .r      (r_q),
    .b      (shift_q[DATA_W-1]),
    .poly   (poly_q),
    .r_next (r_step)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    shift_d    = shift_q;
    poly_d     = poly_q;
    r_d        = r_q;
    crc_hold_d = crc_hold_q;
    crc_out_d  = crc_out_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    in_ready   = 1'b0;
    ser_valid  = 1'b0;
    ser_bit    = 1'b0;
    ser_last   = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          shift_d = in_data;
          poly_d  = genpoly[CRC_W-1:0];
          r_d     = '0;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = DATA;
        end
      end
      DATA: begin
        ser_valid = 1'b1;
        ser_bit   = shift_q[DATA_W-1];
        if (ser_ready) begin
          r_d     = r_step;
          shift_d = shift_q << 1;
          if (cnt_q == '0) begin
            // Snapshot the finished CRC; r_q is consumed bit by bit during CRC.
            crc_hold_d = r_step;
            cnt_d      = CNT_W'(CRC_W - 1);
            state_d    = CRC;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      CRC: begin
        ser_valid = 1'b1;
        ser_bit   = r_q[CRC_W-1];
        ser_last  = (cnt_q == '0);
        if (ser_ready) begin
          r_d = {r_q[CRC_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            crc_out_d = crc_hold_q;
            done_d    = 1'b1;
            state_d   = IDLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      poly_q     <= '0;
      r_q        <= '0;
      crc_hold_q <= '0;
      crc_out_q  <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      poly_q     <= poly_d;
      r_q        <= r_d;
      crc_hold_q <= crc_hold_d;
      crc_out_q  <= crc_out_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
    end
  end

  assign frame_done = done_q;
  assign crc_out    = crc_out_q;

endmodule

// File: tb/tb_crc_serial_tx.sv
// Directed bench for crc_serial_tx: hand-computed codewords, stalls, ignored input, mid-frame reset.
module tb_crc_serial_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_data;
  logic [3:0] genpoly;
  logic       ser_valid;
  logic       ser_ready;
  logic       ser_bit;
  logic       ser_last;
  logic       frame_done;
  logic [2:0] crc_out;

  int n_cmp = 0;
  int n_err = 0;

  crc_serial_tx #(.DATA_W(6), .CRC_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .genpoly    (genpoly),
    .ser_valid  (ser_valid),
    .ser_ready  (ser_ready),
    .ser_bit    (ser_bit),
    .ser_last   (ser_last),
    .frame_done (frame_done),
    .crc_out    (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from IDLE at a negedge and collects the 9-bit codeword.
  task automatic run_frame(input string tag, input logic [5:0] data, input logic [3:0] poly,
                           input bit stall, input bit hold_valid,
                           input logic [8:0] exp_stream, input logic [2:0] exp_crc);
    logic [8:0] stream;
    int         idx;
    int         cyc;
    bit         stalled;
    logic       held_bit;
    logic       held_last;
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = data;
    genpoly   = poly;
    ser_ready = 1'b0;
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    in_data = ~data;
    genpoly = 4'b1101;
    check({tag, "_first_valid"}, 32'(ser_valid), 32'd1);
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    stream   = '0;
    idx      = 0;
    cyc      = 0;
    stalled  = 1'b0;
    held_bit = 1'b0;
    held_last = 1'b0;
    while (idx < 9 && cyc < 200) begin
      if (stalled) begin
        check({tag, "_stall_valid"}, 32'(ser_valid), 32'd1);
        check({tag, "_stall_bit"}, 32'(ser_bit), 32'(held_bit));
        check({tag, "_stall_last"}, 32'(ser_last), 32'(held_last));
      end
      if (hold_valid) begin
        in_data = 6'($urandom);
        check({tag, "_ignore_ready"}, 32'(in_ready), 32'd0);
      end
      ser_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ser_valid && ser_ready) begin
        stream[8 - idx] = ser_bit;
        check({tag, "_last"}, 32'(ser_last), 32'(idx == 8));
        idx++;
        stalled = 1'b0;
      end else if (ser_valid) begin
        stalled   = 1'b1;
        held_bit  = ser_bit;
        held_last = ser_last;
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_bit_count"}, 32'(idx), 32'd9);
    ser_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_stream"}, 32'(stream), 32'(exp_stream));
    check({tag, "_crc_out"}, 32'(crc_out), 32'(exp_crc));
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    check({tag, "_end_valid"}, 32'(ser_valid), 32'd0);
    check({tag, "_end_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    check({tag, "_done_low"}, 32'(frame_done), 32'd0);
    check({tag, "_crc_held"}, 32'(crc_out), 32'(exp_crc));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    genpoly   = '0;
    ser_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_ser_valid", 32'(ser_valid), 32'd0);
    check("reset_ser_bit", 32'(ser_bit), 32'd0);
    check("reset_ser_last", 32'(ser_last), 32'd0);
    check("reset_crc_out", 32'(crc_out), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);

    run_frame("f100000", 6'b100000, 4'b1011, 1'b0, 1'b0, 9'b100000_010, 3'b010);
    run_frame("f000001", 6'b000001, 4'b1011, 1'b0, 1'b0, 9'b000001_011, 3'b011);
    run_frame("f101100_stall", 6'b101100, 4'b1011, 1'b1, 1'b0, 9'b101100_000, 3'b000);
    run_frame("f000001_ignore", 6'b000001, 4'b1011, 1'b1, 1'b1, 9'b000001_011, 3'b011);

    // Abort a frame while its 4th data bit is on the wire.
    in_valid = 1'b1;
    in_data  = 6'b100000;
    genpoly  = 4'b1011;
    @(negedge clk);
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_mid_valid", 32'(ser_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    ser_ready = 1'b0;
    check("abort_ser_valid", 32'(ser_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_crc_out", 32'(crc_out), 32'd0);
    check("abort_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    check("abort_no_done", 32'(frame_done), 32'd0);
    check("abort_idle_valid", 32'(ser_valid), 32'd0);

    run_frame("f100000_after_abort", 6'b100000, 4'b1011, 1'b0, 1'b0, 9'b100000_010, 3'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
